// File: rtl/nv_nvdla_pdp_rdma_rdreq_gen.sv
// PDP RDMA read-request generator: splits atom commands into <=8-atom, 256B-contained
// DMA requests gated by a latency-FIFO credit pool. Optional stall counter: NVDLA_PDP_RDMA_RDREQ_STALL_CNT_EN.
module nv_nvdla_pdp_rdma_rdreq_gen #(
    parameter int LAT_DEPTH = 256
) (
    input  logic        nvdla_core_clk,
    input  logic        nvdla_core_rstn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [63:0] cmd_addr,
    input  logic [12:0] cmd_len,
    output logic        dma_rd_req_valid,
    input  logic        dma_rd_req_ready,
    output logic [78:0] dma_rd_req_pd,
    input  logic        rsp_atom_done,
    output logic [31:0] rdreq_stall_cnt
);

    localparam int CW = $clog2(LAT_DEPTH) + 1;
    localparam logic [CW-1:0] CREDIT_MAX = CW'(LAT_DEPTH);

    typedef enum logic [0:0] {IDLE = 1'b0, SPLIT = 1'b1} state_t;

    state_t        state_q, state_d;
    logic [63:0]   cur_addr_q, cur_addr_d;
    logic [13:0]   remaining_q, remaining_d;
    logic [CW-1:0] credit_q, credit_d;
    logic          valid_q, valid_d;
    logic [78:0]   pd_q, pd_d;

    logic          accept_s;
    logic [3:0]    room_s;
    logic [3:0]    chunk_s;
    logic          credit_ok_s;
    logic          out_free_s;
    logic          issue_s;
    logic          stall_s;
    logic [CW:0]   credit_sum_s;
    logic          unused_addr_lsb_s;

    assign unused_addr_lsb_s = ^cmd_addr[4:0];

    // Chunk is capped by the atoms left before the next 256-byte boundary.
    always_comb begin
        room_s = 4'd8 - {1'b0, cur_addr_q[7:5]};
        if (remaining_q < {10'd0, room_s}) begin
            chunk_s = remaining_q[3:0];
        end else begin
            chunk_s = room_s;
        end
        credit_ok_s = (credit_q >= CW'(chunk_s));
        out_free_s  = !valid_q || dma_rd_req_ready;
        issue_s     = (state_q == SPLIT) && credit_ok_s && out_free_s;
        stall_s     = (state_q == SPLIT) && !credit_ok_s && out_free_s;
        accept_s    = cmd_valid && cmd_ready;
    end

    // State register.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    state_d = SPLIT;
                end else begin
                    state_d = IDLE;
                end
            end
            SPLIT: begin
                if (issue_s && (remaining_q == {10'd0, chunk_s})) begin
                    state_d = IDLE;
                end else begin
                    state_d = SPLIT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs depend on the state flop only.
    always_comb begin
        case (state_q)
            IDLE:    cmd_ready = 1'b1;
            SPLIT:   cmd_ready = 1'b0;
            default: cmd_ready = 1'b0;
        endcase
    end

    // Datapath next values: address walk, credit pool and the output register.
    always_comb begin
        cur_addr_d  = cur_addr_q;
        remaining_d = remaining_q;
        valid_d     = valid_q;
        pd_d        = pd_q;
        if (accept_s) begin
            cur_addr_d  = {cmd_addr[63:5], 5'd0};
            remaining_d = {1'b0, cmd_len} + 14'd1;
        end else if (issue_s) begin
            cur_addr_d  = cur_addr_q + {55'd0, chunk_s, 5'd0};
            remaining_d = remaining_q - {10'd0, chunk_s};
        end else begin
            cur_addr_d  = cur_addr_q;
            remaining_d = remaining_q;
        end
        if (issue_s) begin
            valid_d = 1'b1;
            pd_d    = {11'd0, chunk_s - 4'd1, cur_addr_q};
        end else if (dma_rd_req_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
        // A return arriving with a full pool is dropped by the saturation.
        credit_sum_s = {1'b0, credit_q}
                     - (issue_s ? (CW+1)'(chunk_s) : {(CW+1){1'b0}})
                     + (CW+1)'(rsp_atom_done);
        if (credit_sum_s > {1'b0, CREDIT_MAX}) begin
            credit_d = CREDIT_MAX;
        end else begin
            credit_d = credit_sum_s[CW-1:0];
        end
    end

    // Datapath registers.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            cur_addr_q  <= 64'd0;
            remaining_q <= 14'd0;
            credit_q    <= CREDIT_MAX;
            valid_q     <= 1'b0;
            pd_q        <= 79'd0;
        end else begin
            cur_addr_q  <= cur_addr_d;
            remaining_q <= remaining_d;
            credit_q    <= credit_d;
            valid_q     <= valid_d;
            pd_q        <= pd_d;
        end
    end

    assign dma_rd_req_valid = valid_q;
    assign dma_rd_req_pd    = pd_q;

`ifdef NVDLA_PDP_RDMA_RDREQ_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Saturating count of credit-starved cycles.
    always_comb begin
        if (stall_s && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Stall counter register.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            stall_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign rdreq_stall_cnt = stall_cnt_q;
`else
    logic unused_stall_s;
    assign unused_stall_s  = stall_s;
    assign rdreq_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_nv_nvdla_pdp_rdma_rdreq_gen.sv
// Directed bench for nv_nvdla_pdp_rdma_rdreq_gen with a 16-atom credit pool.
module tb_nv_nvdla_pdp_rdma_rdreq_gen;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [63:0] cmd_addr = 64'd0;
    logic [12:0] cmd_len = 13'd0;
    logic        req_valid;
    logic        req_ready = 1'b1;
    logic [78:0] req_pd;
    logic        done = 1'b0;
    logic [31:0] stall_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    nv_nvdla_pdp_rdma_rdreq_gen #(.LAT_DEPTH(16)) dut (
        .nvdla_core_clk   (clk),
        .nvdla_core_rstn  (rstn),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_addr         (cmd_addr),
        .cmd_len          (cmd_len),
        .dma_rd_req_valid (req_valid),
        .dma_rd_req_ready (req_ready),
        .dma_rd_req_pd    (req_pd),
        .rsp_atom_done    (done),
        .rdreq_stall_cnt  (stall_cnt)
    );

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_cmd(input logic [63:0] a, input logic [12:0] l);
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_len   = l;
        step(1);
        cmd_valid = 1'b0;
    endtask

    task automatic give_credit(input int n);
        done = 1'b1;
        step(n);
        done = 1'b0;
    endtask

    function automatic logic [78:0] mk_pd(input logic [14:0] sz, input logic [63:0] a);
        return {sz, a};
    endfunction

    logic [31:0] exp_stall;
    logic [78:0] held_pd;

    initial begin
        step(3);
        chk("rst_cmd_ready", 96'(cmd_ready), 96'd1);
        chk("rst_valid", 96'(req_valid), 96'd0);
        chk("rst_pd", 96'(req_pd), 96'd0);
        chk("rst_credit", 96'(dut.credit_q), 96'd16);
        chk("rst_stall", 96'(stall_cnt), 96'd0);
        rstn = 1'b1;
        step(1);

        // 13 atoms from 0x1000
        send_cmd(64'h1000, 13'd12);
        chk("a_cmd_ready_busy", 96'(cmd_ready), 96'd0);
        chk("a_no_valid_yet", 96'(req_valid), 96'd0);
        step(1);
        chk("a_req0_valid", 96'(req_valid), 96'd1);
        chk("a_req0_pd", 96'(req_pd), 96'(mk_pd(15'd7, 64'h1000)));
        chk("a_credit0", 96'(dut.credit_q), 96'd8);
        chk("a_busy", 96'(cmd_ready), 96'd0);
        step(1);
        chk("a_req1_pd", 96'(req_pd), 96'(mk_pd(15'd4, 64'h1100)));
        chk("a_credit1", 96'(dut.credit_q), 96'd3);
        chk("a_cmd_ready_back", 96'(cmd_ready), 96'd1);
        step(1);
        chk("a_valid_clear", 96'(req_valid), 96'd0);
        give_credit(13);
        chk("a_credit_full", 96'(dut.credit_q), 96'd16);
        give_credit(1);
        chk("credit_sat_drop", 96'(dut.credit_q), 96'd16);

        // 256-byte boundary split
        send_cmd(64'h10E0, 13'd2);
        step(1);
        chk("b_req0_pd", 96'(req_pd), 96'(mk_pd(15'd0, 64'h10E0)));
        step(1);
        chk("b_req1_pd", 96'(req_pd), 96'(mk_pd(15'd1, 64'h1100)));
        chk("b_cmd_ready", 96'(cmd_ready), 96'd1);
        give_credit(3);
        chk("b_credit", 96'(dut.credit_q), 96'd16);

        // 64-bit address wrap
        send_cmd(64'hFFFF_FFFF_FFFF_FFE0, 13'd1);
        step(1);
        chk("c_req0_pd", 96'(req_pd), 96'(mk_pd(15'd0, 64'hFFFF_FFFF_FFFF_FFE0)));
        step(1);
        chk("c_req1_pd", 96'(req_pd), 96'(mk_pd(15'd0, 64'h0)));
        chk("c_credit", 96'(dut.credit_q), 96'd14);
        give_credit(2);

        // Downstream backpressure for 5 cycles
        send_cmd(64'h2000, 13'd12);
        step(1);
        held_pd = mk_pd(15'd7, 64'h2000);
        chk("d_req0_pd", 96'(req_pd), 96'(held_pd));
        req_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1);
            chk("d_hold_valid", 96'(req_valid), 96'd1);
            chk("d_hold_pd", 96'(req_pd), 96'(held_pd));
        end
        chk("d_hold_credit", 96'(dut.credit_q), 96'd8);
        req_ready = 1'b1;
        step(1);
        chk("d_req1_pd", 96'(req_pd), 96'(mk_pd(15'd4, 64'h2100)));
        chk("d_cmd_ready", 96'(cmd_ready), 96'd1);
        give_credit(13);
        chk("d_valid_clear", 96'(req_valid), 96'd0);
        chk("d_credit", 96'(dut.credit_q), 96'd16);

        // Issue of 8 atoms at credit 8 with a simultaneous return
        send_cmd(64'h3000, 13'd15);
        step(1);
        chk("e_credit8", 96'(dut.credit_q), 96'd8);
        done = 1'b1;
        step(1);
        done = 1'b0;
        chk("e_credit_issue_ret", 96'(dut.credit_q), 96'd1);
        chk("e_req1_pd", 96'(req_pd), 96'(mk_pd(15'd7, 64'h3100)));
        give_credit(15);
        chk("e_credit", 96'(dut.credit_q), 96'd16);

        // Credit exhaustion and stall
`ifdef NVDLA_PDP_RDMA_RDREQ_STALL_CNT_EN
        exp_stall = 32'd4;
`else
        exp_stall = 32'd0;
`endif
        send_cmd(64'h4000, 13'd15);
        step(2);
        chk("f_credit0", 96'(dut.credit_q), 96'd0);
        send_cmd(64'h5000, 13'd15);
        step(4);
        chk("f_stall_valid", 96'(req_valid), 96'd0);
        chk("f_stall_cnt", 96'(stall_cnt), 96'(exp_stall));
        give_credit(8);
`ifdef NVDLA_PDP_RDMA_RDREQ_STALL_CNT_EN
        exp_stall = 32'd12;
`endif
        chk("f_credit8", 96'(dut.credit_q), 96'd8);
        chk("f_still_stalled", 96'(req_valid), 96'd0);
        chk("f_stall_cnt2", 96'(stall_cnt), 96'(exp_stall));
        step(1);
        chk("f_resume_valid", 96'(req_valid), 96'd1);
        chk("f_resume_pd", 96'(req_pd), 96'(mk_pd(15'd7, 64'h5000)));
        chk("f_resume_credit", 96'(dut.credit_q), 96'd0);
        chk("f_stall_cnt3", 96'(stall_cnt), 96'(exp_stall));
        step(1);
        chk("f_busy", 96'(cmd_ready), 96'd0);

        // Asynchronous reset mid-SPLIT
        rstn = 1'b0;
        #1;
        chk("g_rst_valid", 96'(req_valid), 96'd0);
        chk("g_rst_cmd_ready", 96'(cmd_ready), 96'd1);
        chk("g_rst_credit", 96'(dut.credit_q), 96'd16);
        chk("g_rst_stall", 96'(stall_cnt), 96'd0);
        step(2);
        rstn = 1'b1;
        step(3);
        chk("g_no_partial", 96'(req_valid), 96'd0);
        chk("g_idle", 96'(cmd_ready), 96'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/nv_nvdla_pdp_rdma_rdreq_gen.md
NV_NVDLA_PDP_RDMA_RDREQ_GEN -- requirements
Module: nv_nvdla_pdp_rdma_rdreq_gen

Interface
REQ-001 Parameter LAT_DEPTH, default 256, SHALL set the response latency-FIFO capacity in 32-byte atoms (credit pool size, power of two, 16..1024).
REQ-002 Port nvdla_core_clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 Port nvdla_core_rstn  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 Port cmd_valid  input  1  read command valid.
REQ-005 Port cmd_ready  output  1  command accepted when cmd_valid && cmd_ready.
REQ-006 Port cmd_addr  input  64  command base byte address, 32-byte aligned (bits [4:0] ignored).
REQ-007 Port cmd_len  input  13  command length in atoms minus one.
REQ-008 Port dma_rd_req_valid  output  1  read request valid toward the cvif/mcif read-request pipe.
REQ-009 Port dma_rd_req_ready  input  1  downstream accepts when valid && ready.
REQ-010 Port dma_rd_req_pd  output  79  {size[14:0], addr[63:0]}; size = atoms minus one.
REQ-011 Port rsp_atom_done  input  1  one-cycle pulse per atom popped from the latency FIFO (credit return).
REQ-012 Port rdreq_stall_cnt  output  32  cycles stalled for lack of credit (see Configuration).

Function
REQ-013 FSM states IDLE and SPLIT; cmd_ready SHALL equal (state==IDLE), combinational from the state flop only.
REQ-014 Command accept in IDLE SHALL latch cur_addr = {cmd_addr[63:5],5'b0}, remaining = cmd_len+1 (14 bits), and enter SPLIT next cycle.
REQ-015 In SPLIT, chunk = min(remaining, 8 - cur_addr[7:5]); requests SHALL never exceed 8 atoms nor cross a 256-byte boundary.
REQ-016 Issue condition: SPLIT && credit >= chunk && (output register empty || dma_rd_req_ready).
REQ-017 On issue, output register SHALL load {chunk-1, cur_addr} with valid=1 next cycle; cur_addr += chunk*32 (modulo 2^64 wrap); remaining -= chunk; credit -= chunk.
REQ-018 Issue with remaining==chunk SHALL return FSM to IDLE; next command acceptable the following cycle (no bubble beyond that).
REQ-019 Output register SHALL hold valid and pd stable while dma_rd_req_valid && !dma_rd_req_ready; valid SHALL clear on accept with no new issue.
REQ-020 Request latency: first request valid SHALL appear 2 cycles after command accept when credit suffices.
REQ-021 Credit: credit_next = credit - (issue ? chunk : 0) + rsp_atom_done; simultaneous issue and return SHALL both apply in the same cycle.
REQ-022 Credit SHALL saturate at LAT_DEPTH; a return at LAT_DEPTH SHALL be dropped.
REQ-023 Credit width SHALL be clog2(LAT_DEPTH)+1 bits; credit SHALL never go negative (guaranteed by REQ-016).
REQ-024 Stall cycle: SPLIT && credit < chunk && output register able to accept.

Reset
REQ-025 On nvdla_core_rstn low, asynchronously: state=IDLE, cmd_ready=1, dma_rd_req_valid=0, dma_rd_req_pd=0, credit=LAT_DEPTH, remaining=0, cur_addr=0, rdreq_stall_cnt=0.
REQ-026 Reset mid-command SHALL abandon the command; no partial request SHALL be emitted after deassertion.

Configuration
REQ-027 Macro NVDLA_PDP_RDMA_RDREQ_STALL_CNT_EN defined: rdreq_stall_cnt SHALL increment by 1 each stall cycle, saturating at 32'hFFFFFFFF, cleared only by reset.
REQ-028 Macro undefined: no counter flops; rdreq_stall_cnt SHALL be tied to 32'h0; all other behaviour identical.

Verification
REQ-029 Addr 0x1000, len 12 (13 atoms), ready=1 -> requests {7,0x1000},{4,0x1100}; cmd_ready returns 1 after second issue.
REQ-030 Addr 0x10E0, len 2 -> requests {0,0x10E0},{1,0x1100} (boundary split).
REQ-031 LAT_DEPTH=16, two 16-atom commands, no rsp_atom_done -> exactly 16 atoms issued then stall; stall_cnt increments (macro on) / stays 0 (macro off); 8 rsp_atom_done pulses -> next 8-atom request issues.
REQ-032 dma_rd_req_ready held 0 for 5 cycles mid-stream -> valid and pd unchanged for those cycles, no request lost or duplicated.
REQ-033 Issue of 8 atoms coincident with rsp_atom_done at credit=8 -> credit=1 next cycle; return at credit=LAT_DEPTH -> credit unchanged.
REQ-034 Addr 0xFFFFFFFFFFFFFFE0, len 1 -> requests {0,0xFFFFFFFFFFFFFFE0},{0,0x0}; reset asserted mid-SPLIT -> valid=0, cmd_ready=1, credit=LAT_DEPTH immediately.
